// File: rtl/frame_proc_sequencer.sv
// Sequencer for the edge-detect pipeline: on a captured frame it runs the black-white
// engine then the Sobel engine, hands out buffer ports, and guards each run with a watchdog.
module frame_proc_sequencer #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TIMEOUT_W      = 22
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_edge_i,
    input  logic       frame_done_i,
    input  logic       vsync_i,
    input  logic       bw_done_i,
    input  logic       ed_done_i,
    output logic       bw_rst_o,
    output logic       ed_rst_o,
    output logic       bw_en_o,
    output logic       ed_en_o,
    output logic [1:0] buf1_rd_sel_o,
    output logic [1:0] buf1_wr_sel_o,
    output logic       buf2_wr_gate_o,
    output logic       display_sel_o,
    output logic       busy_o,
    output logic       err_timeout_o,
    output logic [7:0] frames_done_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        NORMAL  = 3'd0,
        BW_RST  = 3'd1,
        BW_RUN  = 3'd2,
        BW_DONE = 3'd3,
        ED_RST  = 3'd4,
        ED_RUN  = 3'd5,
        ED_DONE = 3'd6,
        ABORT   = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 err;
    logic [7:0]           frames;
    logic                 in_run;
    logic                 run_done;
    logic                 expired;

    always_comb begin
        in_run   = (state == BW_RUN) || (state == ED_RUN);
        run_done = (state == BW_RUN) ? bw_done_i : ed_done_i;
        expired  = in_run && !run_done && (wdog == WD_LAST);
    end

    // A dropped mode switch outranks expiry, so only a genuine timeout raises the error flag.
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (mode_edge_i && frame_done_i) state_nxt = BW_RST;
            BW_RST:  state_nxt = BW_RUN;
            BW_RUN: begin
                if (bw_done_i)                    state_nxt = BW_DONE;
                else if (!mode_edge_i || expired) state_nxt = ABORT;
            end
            BW_DONE: state_nxt = ED_RST;
            ED_RST:  state_nxt = ED_RUN;
            ED_RUN: begin
                if (ed_done_i)                    state_nxt = ED_DONE;
                else if (!mode_edge_i || expired) state_nxt = ABORT;
            end
            ED_DONE: state_nxt = NORMAL;
            ABORT:   state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= NORMAL;
            wdog   <= '0;
            err    <= 1'b0;
            frames <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == BW_RST || state == ED_RST) wdog <= '0;
            else if (in_run)                        wdog <= wdog + 1'b1;
            if (expired && mode_edge_i) err    <= 1'b1;
            if (state == ED_DONE)       frames <= frames + 8'd1;
        end
    end

    // While reset is held every output reads as idle, whatever the registers hold.
    always_comb begin
        bw_rst_o       = rst_i;
        ed_rst_o       = rst_i;
        bw_en_o        = 1'b0;
        ed_en_o        = 1'b0;
        buf1_rd_sel_o  = 2'd0;
        buf1_wr_sel_o  = 2'd0;
        buf2_wr_gate_o = 1'b0;
        display_sel_o  = mode_edge_i;
        busy_o         = 1'b0;
        err_timeout_o  = 1'b0;
        frames_done_o  = 8'd0;
        state_o        = 3'd0;
        if (!rst_i) begin
            state_o       = state;
            busy_o        = (state != NORMAL);
            err_timeout_o = err;
            frames_done_o = frames;
            display_sel_o = !((state == NORMAL) && !mode_edge_i);
            case (state)
                BW_RST, BW_DONE: bw_rst_o = 1'b1;
                ED_RST, ED_DONE: ed_rst_o = 1'b1;
                ABORT: begin
                    bw_rst_o = 1'b1;
                    ed_rst_o = 1'b1;
                end
                BW_RUN: begin
                    bw_en_o       = !vsync_i;
                    buf1_rd_sel_o = 2'd1;
                    buf1_wr_sel_o = 2'd1;
                end
                ED_RUN: begin
                    ed_en_o        = !vsync_i;
                    buf1_rd_sel_o  = 2'd2;
                    buf1_wr_sel_o  = 2'd2;
                    buf2_wr_gate_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_proc_sequencer.sv
// Directed bench for frame_proc_sequencer: one instance with the default watchdog and one with
// a 16-cycle watchdog share the stimulus; per-cycle expected snapshots go through a queue.
module tb_frame_proc_sequencer;

    logic clk = 1'b0;
    logic rst, mode, frame_done, vsync, bw_done, ed_done;
    logic use16;

    logic       a_bw_rst, a_ed_rst, a_bw_en, a_ed_en, a_gate, a_disp, a_busy, a_err;
    logic [1:0] a_rd, a_wr;
    logic [7:0] a_frames;
    logic [2:0] a_state;
    logic       b_bw_rst, b_ed_rst, b_bw_en, b_ed_en, b_gate, b_disp, b_busy, b_err;
    logic [1:0] b_rd, b_wr;
    logic [7:0] b_frames;
    logic [2:0] b_state;

    logic [22:0] obs_a, obs_b;

    typedef struct {
        string       tag;
        logic [22:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    frame_proc_sequencer dut (
        .clk_i(clk), .rst_i(rst), .mode_edge_i(mode), .frame_done_i(frame_done),
        .vsync_i(vsync), .bw_done_i(bw_done), .ed_done_i(ed_done),
        .bw_rst_o(a_bw_rst), .ed_rst_o(a_ed_rst), .bw_en_o(a_bw_en), .ed_en_o(a_ed_en),
        .buf1_rd_sel_o(a_rd), .buf1_wr_sel_o(a_wr), .buf2_wr_gate_o(a_gate),
        .display_sel_o(a_disp), .busy_o(a_busy), .err_timeout_o(a_err),
        .frames_done_o(a_frames), .state_o(a_state)
    );

    frame_proc_sequencer #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(4)) dut16 (
        .clk_i(clk), .rst_i(rst), .mode_edge_i(mode), .frame_done_i(frame_done),
        .vsync_i(vsync), .bw_done_i(bw_done), .ed_done_i(ed_done),
        .bw_rst_o(b_bw_rst), .ed_rst_o(b_ed_rst), .bw_en_o(b_bw_en), .ed_en_o(b_ed_en),
        .buf1_rd_sel_o(b_rd), .buf1_wr_sel_o(b_wr), .buf2_wr_gate_o(b_gate),
        .display_sel_o(b_disp), .busy_o(b_busy), .err_timeout_o(b_err),
        .frames_done_o(b_frames), .state_o(b_state)
    );

    assign obs_a = {a_state, a_bw_rst, a_ed_rst, a_bw_en, a_ed_en, a_rd, a_wr,
                    a_gate, a_disp, a_busy, a_err, a_frames};
    assign obs_b = {b_state, b_bw_rst, b_ed_rst, b_bw_en, b_ed_en, b_rd, b_wr,
                    b_gate, b_disp, b_busy, b_err, b_frames};

    // Output table of the sequencer for a given state and the inputs currently driven.
    function automatic logic [22:0] expv(input logic [2:0] st, input logic er, input logic [7:0] fr);
        logic [2:0] s;
        logic       br, erst, be, ee, g, d, b, e;
        logic [1:0] rd, wr;
        logic [7:0] f;
        if (rst) begin
            s = 3'd0; br = 1'b1; erst = 1'b1; be = 1'b0; ee = 1'b0;
            rd = 2'd0; wr = 2'd0; g = 1'b0; d = mode; b = 1'b0; e = 1'b0; f = 8'd0;
        end else begin
            s    = st;
            br   = (st == 3'd1) || (st == 3'd3) || (st == 3'd7);
            erst = (st == 3'd4) || (st == 3'd6) || (st == 3'd7);
            be   = (st == 3'd2) && !vsync;
            ee   = (st == 3'd5) && !vsync;
            rd   = (st == 3'd2) ? 2'd1 : ((st == 3'd5) ? 2'd2 : 2'd0);
            wr   = rd;
            g    = (st == 3'd5);
            d    = !((st == 3'd0) && !mode);
            b    = (st != 3'd0);
            e    = er;
            f    = fr;
        end
        return {s, br, erst, be, ee, rd, wr, g, d, b, e, f};
    endfunction

    // Push the expected snapshot for this cycle, sample mid-cycle, compare, advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic er, input logic [7:0] fr);
        exp_t        e;
        logic [22:0] obs;
        e.tag = tag;
        e.val = expv(st, er, fr);
        sb.push_back(e);
        #2;
        e   = sb.pop_front();
        obs = use16 ? obs_b : obs_a;
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    // One complete edge-detect pass with immediate done responses; mode must be 1.
    task automatic pass_fast(input logic er, input logic [7:0] fr);
        frame_done = 1'b1; cyc("pf_trig", 3'd0, er, fr); frame_done = 1'b0;
        cyc("pf_bwrst", 3'd1, er, fr);
        bw_done = 1'b1; cyc("pf_bwrun", 3'd2, er, fr); bw_done = 1'b0;
        cyc("pf_bwdone", 3'd3, er, fr);
        cyc("pf_edrst", 3'd4, er, fr);
        ed_done = 1'b1; cyc("pf_edrun", 3'd5, er, fr); ed_done = 1'b0;
        cyc("pf_eddone", 3'd6, er, fr);
        cyc("pf_end", 3'd0, er, fr + 8'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, observed running expected done");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; frame_done = 1'b0; vsync = 1'b0;
        bw_done = 1'b0; ed_done = 1'b0; use16 = 1'b0;
        @(posedge clk);
        #1;

        // reset values, display following the switch during reset
        cyc("rst_m0", 3'd0, 1'b0, 8'd0);
        mode = 1'b1; cyc("rst_m1", 3'd0, 1'b0, 8'd0);
        use16 = 1'b1; cyc("rst16", 3'd0, 1'b0, 8'd0);
        use16 = 1'b0; mode = 1'b0; rst = 1'b0;
        cyc("idle", 3'd0, 1'b0, 8'd0);

        // normal video: frame pulses ignored, toggle only moves display_sel
        for (int i = 0; i < 3; i++) begin
            frame_done = 1'b1; cyc("norm_fd", 3'd0, 1'b0, 8'd0); frame_done = 1'b0;
            cyc("norm_gap", 3'd0, 1'b0, 8'd0);
            cyc("norm_gap", 3'd0, 1'b0, 8'd0);
        end
        mode = 1'b1; cyc("norm_mode1", 3'd0, 1'b0, 8'd0);
        mode = 1'b0; cyc("norm_mode0", 3'd0, 1'b0, 8'd0);

        // full pass: T trigger, bw_done at T+10, ed_done at T+30
        mode = 1'b1;
        frame_done = 1'b1; cyc("fp_T", 3'd0, 1'b0, 8'd0); frame_done = 1'b0;
        cyc("fp_T1", 3'd1, 1'b0, 8'd0);
        cyc("fp_T2", 3'd2, 1'b0, 8'd0);
        vsync = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame_done = (i == 2);
            cyc("fp_vsync_bw", 3'd2, 1'b0, 8'd0);
            frame_done = 1'b0;
        end
        vsync = 1'b0;
        cyc("fp_bwrun", 3'd2, 1'b0, 8'd0);
        cyc("fp_bwrun", 3'd2, 1'b0, 8'd0);
        bw_done = 1'b1; cyc("fp_T10", 3'd2, 1'b0, 8'd0); bw_done = 1'b0;
        cyc("fp_T11", 3'd3, 1'b0, 8'd0);
        cyc("fp_T12", 3'd4, 1'b0, 8'd0);
        for (int i = 0; i < 17; i++) begin
            vsync = (i == 7) || (i == 8);
            cyc("fp_edrun", 3'd5, 1'b0, 8'd0);
        end
        vsync = 1'b0;
        ed_done = 1'b1; cyc("fp_T30", 3'd5, 1'b0, 8'd0); ed_done = 1'b0;
        cyc("fp_T31", 3'd6, 1'b0, 8'd0);
        cyc("fp_T32", 3'd0, 1'b0, 8'd1);
        cyc("fp_after", 3'd0, 1'b0, 8'd1);

        // watchdog on the 16-cycle instance, vsync does not pause the count
        use16 = 1'b1;
        rst = 1'b1; cyc("to_rst", 3'd0, 1'b0, 8'd0); rst = 1'b0;
        frame_done = 1'b1; cyc("to_trig", 3'd0, 1'b0, 8'd0); frame_done = 1'b0;
        cyc("to_bwrst", 3'd1, 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            vsync = (i >= 3) && (i < 8);
            cyc("to_run", 3'd2, 1'b0, 8'd0);
        end
        vsync = 1'b0;
        cyc("to_abort", 3'd7, 1'b1, 8'd0);
        cyc("to_idle", 3'd0, 1'b1, 8'd0);
        cyc("to_sticky", 3'd0, 1'b1, 8'd0);

        // reset in ED_RUN with frames_done=3 and err=1
        pass_fast(1'b1, 8'd0);
        pass_fast(1'b1, 8'd1);
        pass_fast(1'b1, 8'd2);
        frame_done = 1'b1; cyc("rm_trig", 3'd0, 1'b1, 8'd3); frame_done = 1'b0;
        cyc("rm_bwrst", 3'd1, 1'b1, 8'd3);
        bw_done = 1'b1; cyc("rm_bwrun", 3'd2, 1'b1, 8'd3); bw_done = 1'b0;
        cyc("rm_bwdone", 3'd3, 1'b1, 8'd3);
        cyc("rm_edrst", 3'd4, 1'b1, 8'd3);
        cyc("rm_edrun", 3'd5, 1'b1, 8'd3);
        rst = 1'b1; cyc("rm_rst", 3'd0, 1'b0, 8'd0); rst = 1'b0;
        cyc("rm_after", 3'd0, 1'b0, 8'd0);

        // mode drop in ED_RUN on the default instance
        use16 = 1'b0;
        rst = 1'b1; cyc("md_rst", 3'd0, 1'b0, 8'd0); rst = 1'b0;
        frame_done = 1'b1; cyc("md_trig", 3'd0, 1'b0, 8'd0); frame_done = 1'b0;
        cyc("md_bwrst", 3'd1, 1'b0, 8'd0);
        bw_done = 1'b1; cyc("md_bwrun", 3'd2, 1'b0, 8'd0); bw_done = 1'b0;
        cyc("md_bwdone", 3'd3, 1'b0, 8'd0);
        cyc("md_edrst", 3'd4, 1'b0, 8'd0);
        mode = 1'b0; ed_done = 1'b1; cyc("md_done", 3'd5, 1'b0, 8'd0); ed_done = 1'b0;
        cyc("md_eddone", 3'd6, 1'b0, 8'd0);
        cyc("md_end", 3'd0, 1'b0, 8'd1);
        mode = 1'b1;
        frame_done = 1'b1; cyc("ma_trig", 3'd0, 1'b0, 8'd1); frame_done = 1'b0;
        cyc("ma_bwrst", 3'd1, 1'b0, 8'd1);
        bw_done = 1'b1; cyc("ma_bwrun", 3'd2, 1'b0, 8'd1); bw_done = 1'b0;
        cyc("ma_bwdone", 3'd3, 1'b0, 8'd1);
        cyc("ma_edrst", 3'd4, 1'b0, 8'd1);
        cyc("ma_edrun", 3'd5, 1'b0, 8'd1);
        mode = 1'b0; cyc("ma_drop", 3'd5, 1'b0, 8'd1);
        cyc("ma_abort", 3'd7, 1'b0, 8'd1);
        cyc("ma_end", 3'd0, 1'b0, 8'd1);

        // frames_done wraps from 255 to 0
        mode = 1'b1;
        for (int i = 1; i < 256; i++) pass_fast(1'b0, 8'(i));
        cyc("wrap", 3'd0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
